rp_bram_rd_sm: RTL
==================

// Module: rp_bram_rd_sm
// PURPOSE
// - Read-side counterpart to the ADC acquisition write-pointer state machine. After a capture it streams a
//   window of the circular acquisition BRAM: pre-trigger samples first, then post-trigger samples.
// - Computes the start address from the trigger write pointer, issues BRAM reads with wrap-around and
//   absorbs the fixed BRAM read latency.
// - Delivers samples on a valid/ready stream toward the DMA/AXI readout path.
// PARAMETERS
// - RSZ     14  BRAM address width; buffer depth 2**RSZ samples
// - DW      16  sample width
// - RD_LAT   2  BRAM read latency in clocks (addr/en to data valid), 1..3
// PORTS
// - adc_clk_i     in   1      ADC clock; all logic is on this single clock
// - adc_rstn_i    in   1      reset, asynchronous, active-low
// - rd_start_i    in   1      one-cycle pulse: begin a readout; ignored while busy_o=1
// - rd_abort_i    in   1      one-cycle pulse: cancel the readout in progress
// - wp_trig_i     in   RSZ    write pointer saved at trigger, sampled at start
// - we_cnt_i      in   32     samples written before trigger, sampled at start
// - pre_len_i     in   RSZ    requested pre-trigger samples
// - len_i         in   RSZ+1  total samples to read (0..2**RSZ)
// - bram_en_o     out  1      BRAM read enable
// - bram_addr_o   out  RSZ    BRAM read address
// - bram_data_i   in   DW     BRAM read data, valid RD_LAT clocks after bram_en_o
// - m_data_o      out  DW     stream data
// - m_valid_o     out  1      stream valid
// - m_last_o      out  1      final sample of the window
// - m_ready_i     in   1      stream ready
// - busy_o        out  1      high from the cycle after an accepted start until return to IDLE
// - done_o        out  1      one-cycle pulse when the last sample is accepted (not raised on abort)
// - rd_cnt_o      out  RSZ+1  samples accepted downstream in the current window
// - state_o       out  2      current FSM state, for status readback
// BEHAVIOUR
// - Reset: all outputs 0; FSM=IDLE; FIFO empty; outstanding-read count 0.
// - IDLE: a start pulse latches the inputs.
//   - pre_eff = min(pre_len_i, we_cnt_i, len_i), so reads never reach unwritten locations.
//   - len_eff = min(len_i, 2**RSZ).
//   - Goes to SETUP; with len_eff=0 it goes straight to IDLE and pulses done_o the next cycle.
// - SETUP (1 clk): addr = wp_trig_i - pre_eff, modulo 2**RSZ; issue_cnt = len_eff. Then STREAM.
// - STREAM: issue a read when issue_cnt>0 and (outstanding + fifo_count) < FIFO_DEPTH.
//   - Each issue: addr += 1 (wraps from 2**RSZ-1 to 0); issue_cnt -= 1.
//   - When issue_cnt reaches 0, go to DRAIN.
// - DRAIN: no new issues; stay until the last sample is accepted (m_valid_o & m_ready_i & m_last_o),
//   then IDLE with done_o pulsed that cycle.
// - Return data is pushed into the output FIFO RD_LAT clocks after issue, via an RD_LAT-deep valid pipe.
//   - FIFO_DEPTH = RD_LAT+2, so a full window streams with no bubbles while m_ready_i stays high.
//   - First-sample latency from rd_start_i: 2 + RD_LAT clocks (+1 for the FIFO register).
// - m_last_o is high exactly when the sample presented is number len_eff.
//   - m_data_o, m_valid_o and m_last_o hold stable while m_valid_o=1 and m_ready_i=0.
// - rd_cnt_o clears on an accepted start and increments on each accepted sample.
// - Abort, from any non-IDLE state: stop issuing at once; drop in-flight returns; flush the FIFO;
//   m_valid_o=0 from the next clock; IDLE within RD_LAT+1 clocks; no done_o.
// - Abort and start in the same cycle: abort wins, start is ignored. Start while busy: ignored, no effect.
// - Wrap-around: a window may straddle address 0; a full window (2**RSZ) visits every address exactly once.
// - Async reset mid-readout: immediate return to reset values; no partial done_o.
// - State encoding: IDLE=0, SETUP=1, STREAM=2, DRAIN=3.
// STRUCTURE
// - Shared package/include rp_bram_pkg: FSM state encodings, RD_LAT default, FIFO_DEPTH formula.
// - Sub-module rp_bram_rd_fifo: small synchronous FIFO with count output and a flush input.
// - Top level holds the FSM, address/issue counters, the latency valid pipe and the last-sample tagging.
// TESTING
// - T1: wp_trig=100, we_cnt=5000, pre=10, len=20, ready=1
//       -> addresses 90..109; data equals address; m_last on the 20th sample; one done_o.
// - T2: wp_trig=3, pre=8, len=16, RSZ=14
//       -> addresses 16379..16383 then 0..10, contiguous with no gap.
// - T3: we_cnt=4, pre=10, len=12
//       -> pre clamped to 4; first address wp_trig-4; 12 samples delivered.
// - T4: m_ready toggling randomly 50% over a len=64 window
//       -> no sample lost or duplicated; outputs stable while stalled; rd_cnt_o ends at 64.
// - T5: abort after 7 accepted samples, with ready=0 and the FIFO full
//       -> m_valid_o=0 next clock; IDLE within RD_LAT+1 clocks; no done_o; the next start reads cleanly.
// - T6: len=0 -> no m_valid_o, done_o one clock after start.
//       len=16384 -> every address visited exactly once.
//       start+abort in the same cycle -> stays IDLE.

Source files
------------

// File: rtl/rp_bram_pkg.sv
// Shared definitions for the acquisition BRAM readout path.
// Contents:
//   rd_state_e  - readout FSM state encoding (status-visible, fixed values)
//   RD_LAT_DEF  - default BRAM read latency in clocks
//   fifo_depth  - output FIFO depth for a given read latency
package rp_bram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } rd_state_e;

  localparam int unsigned RD_LAT_DEF = 2;

  // Two slots beyond the read latency cover the FIFO register and one
  // sample in flight to the consumer, so a ready-high stream has no bubbles.
  function automatic int unsigned fifo_depth(input int unsigned rd_lat);
    return rd_lat + 2;
  endfunction

endpackage

// File: rtl/rp_bram_rd_fifo.sv
// Small synchronous FIFO for the readout return path.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   flush       - empties the FIFO (wins over push/pop)
//   push        - write push_data (caller guarantees space)
//   push_data   - write data
//   pop         - remove the head entry (ignored when empty)
//   head        - current head entry, stable until popped
//   count       - number of stored entries
//   empty       - no entries stored
module rp_bram_rd_fifo #(
  parameter int unsigned W     = 17,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          empty
);

  localparam int unsigned   AW       = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;

  assign empty  = (count == '0);
  assign do_pop = pop && !empty;
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rp_bram_rd_sm.sv
// Readout state machine for the circular ADC acquisition BRAM. After a
// capture it streams pre-trigger then post-trigger samples, wrapping at the
// buffer end, absorbing the BRAM read latency and presenting a valid/ready
// stream.
// Ports:
//   adc_clk_i, adc_rstn_i      - clock, asynchronous active-low reset
//   rd_start_i, rd_abort_i     - start / cancel pulses
//   wp_trig_i, we_cnt_i        - trigger write pointer, samples written pre-trigger
//   pre_len_i, len_i           - requested pre-trigger count, window length
//   bram_en_o, bram_addr_o     - BRAM read port request
//   bram_data_i                - BRAM read data, RD_LAT clocks after request
//   m_data_o, m_valid_o,
//   m_last_o, m_ready_i        - output sample stream
//   busy_o, done_o             - status: readout active, window completed pulse
//   rd_cnt_o, state_o          - samples accepted in this window, FSM state
module rp_bram_rd_sm
  import rp_bram_pkg::*;
#(
  parameter int unsigned RSZ    = 14,
  parameter int unsigned DW     = 16,
  parameter int unsigned RD_LAT = RD_LAT_DEF
) (
  input  logic           adc_clk_i,
  input  logic           adc_rstn_i,
  input  logic           rd_start_i,
  input  logic           rd_abort_i,
  input  logic [RSZ-1:0] wp_trig_i,
  input  logic [31:0]    we_cnt_i,
  input  logic [RSZ-1:0] pre_len_i,
  input  logic [RSZ:0]   len_i,
  output logic           bram_en_o,
  output logic [RSZ-1:0] bram_addr_o,
  input  logic [DW-1:0]  bram_data_i,
  output logic [DW-1:0]  m_data_o,
  output logic           m_valid_o,
  output logic           m_last_o,
  input  logic           m_ready_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [RSZ:0]   rd_cnt_o,
  output logic [1:0]     state_o
);

  localparam int unsigned DEPTH    = fifo_depth(RD_LAT);
  localparam int unsigned CW       = $clog2(DEPTH + 1);
  localparam logic [RSZ:0] FULL_LEN = {1'b1, {RSZ{1'b0}}};

  rd_state_e      state;
  rd_state_e      state_nxt;
  logic [RSZ-1:0] wp_lat;
  logic [RSZ-1:0] pre_lat;
  logic [RSZ:0]   len_lat;
  logic [RSZ-1:0] addr;
  logic [RSZ:0]   issue_cnt;
  logic [RSZ:0]   rd_cnt;
  logic [RSZ:0]   len_eff;
  logic [RSZ-1:0] pre_eff;
  logic [RD_LAT-1:0] vpipe;
  logic [RD_LAT-1:0] lpipe;
  logic [CW-1:0]  outstanding;
  logic [CW-1:0]  fifo_count;
  logic [CW:0]    inflight;
  logic           fifo_empty;
  logic [DW:0]    fifo_head;
  logic           room;
  logic           issue;
  logic           last_issue;
  logic           flush;
  logic           accept;
  logic           accept_start;
  logic           done;

  // Clamp the window to what exists: never more than the buffer, and never
  // reach back past the first written sample or beyond the window itself.
  always_comb begin
    len_eff = (len_i > FULL_LEN) ? FULL_LEN : len_i;
    pre_eff = pre_len_i;
    if (we_cnt_i < 32'(pre_eff)) begin
      pre_eff = we_cnt_i[RSZ-1:0];
    end
    if ({1'b0, pre_eff} > len_i) begin
      pre_eff = len_i[RSZ-1:0];
    end
  end

  always_comb begin
    outstanding = '0;
    for (int unsigned i = 0; i < RD_LAT; i++) begin
      outstanding = outstanding + CW'(vpipe[i]);
    end
  end

  assign inflight     = {1'b0, outstanding} + {1'b0, fifo_count};
  assign room         = inflight < (CW + 1)'(DEPTH);
  assign accept       = m_valid_o && m_ready_i;
  assign accept_start = (state == ST_IDLE) && rd_start_i && !rd_abort_i;
  assign last_issue   = (issue_cnt == (RSZ + 1)'(1));

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    flush     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept_start && (len_eff != '0)) begin
          state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        issue = (issue_cnt != '0) && room;
        if (issue && last_issue) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (accept && m_last_o) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (rd_abort_i && (state != ST_IDLE)) begin
      state_nxt = ST_IDLE;
      issue     = 1'b0;
      flush     = 1'b1;
    end
  end

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      wp_lat    <= '0;
      pre_lat   <= '0;
      len_lat   <= '0;
      addr      <= '0;
      issue_cnt <= '0;
      rd_cnt    <= '0;
      vpipe     <= '0;
      lpipe     <= '0;
      done      <= 1'b0;
    end else begin
      if (accept_start) begin
        wp_lat  <= wp_trig_i;
        pre_lat <= pre_eff;
        len_lat <= len_eff;
      end

      if (state == ST_SETUP) begin
        addr      <= wp_lat - pre_lat;
        issue_cnt <= len_lat;
      end else if (issue) begin
        addr      <= addr + 1'b1;
        issue_cnt <= issue_cnt - 1'b1;
      end

      // Read-return tracking: a set bit in the last stage means bram_data_i
      // carries a requested sample this cycle. Abort drops in-flight returns.
      vpipe[0] <= issue && !flush;
      lpipe[0] <= last_issue;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        vpipe[i] <= vpipe[i-1] && !flush;
        lpipe[i] <= lpipe[i-1];
      end

      if (accept_start) begin
        rd_cnt <= '0;
      end else if (accept) begin
        rd_cnt <= rd_cnt + 1'b1;
      end

      done <= (accept_start && (len_eff == '0)) ||
              ((state == ST_DRAIN) && accept && m_last_o && !flush);
    end
  end

  // The last-sample tag travels with the data so m_last_o needs no counter
  // comparison at the output.
  rp_bram_rd_fifo #(
    .W    (DW + 1),
    .DEPTH(DEPTH),
    .CW   (CW)
  ) u_fifo (
    .clk      (adc_clk_i),
    .rst_n    (adc_rstn_i),
    .flush    (flush),
    .push     (vpipe[RD_LAT-1] && !flush),
    .push_data({lpipe[RD_LAT-1], bram_data_i}),
    .pop      (accept),
    .head     (fifo_head),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );

  assign bram_en_o   = issue;
  assign bram_addr_o = addr;
  assign m_data_o    = fifo_head[DW-1:0];
  assign m_valid_o   = !fifo_empty;
  assign m_last_o    = fifo_head[DW] && !fifo_empty;
  assign busy_o      = (state != ST_IDLE);
  assign done_o      = done;
  assign rd_cnt_o    = rd_cnt;
  assign state_o     = state;

endmodule
